// File: rtl/i2c_slave.sv
// I2C target (responder). Oversamples sclk/sda on the system clock, detects
// START/STOP, matches a 7-bit address, receives write bytes into rx_data and
// serves read bytes from tx_data. SDA is driven open-drain through sda_oe.
module i2c_slave #(
    parameter logic [6:0] ADDR = 7'h42
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sclk,
    input  logic       sda_in,
    output logic       sda_oe,
    input  logic [7:0] tx_data,
    output logic       tx_load,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic [3:0] state,
    output logic       busy
);

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        ADDR_RX  = 4'd1,
        ADDR_ACK = 4'd2,
        RX       = 4'd3,
        RX_ACK   = 4'd4,
        TX       = 4'd5,
        TX_ACK   = 4'd6,
        WAIT     = 4'd7
    } state_t;

    state_t     state_q;

    // Synchroniser and history flops for both bus lines.
    logic       scl_s1, scl_s2, scl_h;
    logic       sda_s1, sda_s2, sda_h;

    // Bus event strobes, one clk wide.
    logic       scl_rise, scl_fall;
    logic       start_det, stop_det;

    // Bit bookkeeping and shift registers.
    logic [2:0] bit_cnt;
    logic       byte_done;
    logic [7:0] shreg;
    logic [6:0] tx_rest;
    logic       rw;
    logic       mack;

    // Two-flop synchronisers plus a history flop; reset to 1 so an idle bus
    // never looks like an edge coming out of reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge value of its neighbours, like real hardware.
        if (rst) begin
            scl_s1 <= 1'b1;
            scl_s2 <= 1'b1;
            scl_h  <= 1'b1;
            sda_s1 <= 1'b1;
            sda_s2 <= 1'b1;
            sda_h  <= 1'b1;
        end else begin
            scl_s1 <= sclk;
            scl_s2 <= scl_s1;
            scl_h  <= scl_s2;
            sda_s1 <= sda_in;
            sda_s2 <= sda_s1;
            sda_h  <= sda_s2;
        end
    end

    assign scl_rise  = scl_s2 & ~scl_h;
    assign scl_fall  = ~scl_s2 & scl_h;
    assign start_det = scl_s2 & scl_h & sda_h & ~sda_s2;
    assign stop_det  = scl_s2 & scl_h & ~sda_h & sda_s2;

    // Protocol FSM: all outputs registered; START/STOP override every state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            sda_oe    <= 1'b0;
            tx_load   <= 1'b0;
            rx_data   <= 8'h00;
            rx_valid  <= 1'b0;
            bit_cnt   <= 3'd0;
            byte_done <= 1'b0;
            shreg     <= 8'h00;
            tx_rest   <= 7'h00;
            rw        <= 1'b0;
            mack      <= 1'b1;
        end else begin
            tx_load  <= 1'b0;
            rx_valid <= 1'b0;

            if (stop_det) begin
                state_q   <= IDLE;
                sda_oe    <= 1'b0;
                bit_cnt   <= 3'd0;
                byte_done <= 1'b0;
            end else if (start_det) begin
                state_q   <= ADDR_RX;
                sda_oe    <= 1'b0;
                bit_cnt   <= 3'd0;
                byte_done <= 1'b0;
            end else begin
                // NOTE: a default arm plus registers holding their value keeps
                // this block free of unintended latch/hold ambiguity.
                unique case (state_q)
                    IDLE: ;

                    ADDR_RX: begin
                        if (scl_rise && !byte_done) begin
                            shreg   <= {shreg[6:0], sda_s2};
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) byte_done <= 1'b1;
                        end else if (scl_fall && byte_done) begin
                            byte_done <= 1'b0;
                            if (shreg[7:1] == ADDR) begin
                                rw      <= shreg[0];
                                sda_oe  <= 1'b1;
                                state_q <= ADDR_ACK;
                            end else begin
                                state_q <= WAIT;
                            end
                        end
                    end

                    ADDR_ACK: begin
                        if (scl_fall) begin
                            if (!rw) begin
                                sda_oe  <= 1'b0;
                                state_q <= RX;
                            end else begin
                                tx_load <= 1'b1;
                                tx_rest <= tx_data[6:0];
                                sda_oe  <= ~tx_data[7];
                                state_q <= TX;
                            end
                        end
                    end

                    RX: begin
                        if (scl_rise && !byte_done) begin
                            shreg   <= {shreg[6:0], sda_s2};
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                byte_done <= 1'b1;
                                rx_data   <= {shreg[6:0], sda_s2};
                                rx_valid  <= 1'b1;
                            end
                        end else if (scl_fall && byte_done) begin
                            byte_done <= 1'b0;
                            sda_oe    <= 1'b1;
                            state_q   <= RX_ACK;
                        end
                    end

                    RX_ACK: begin
                        // Every byte is acknowledged; there is no backpressure.
                        if (scl_fall) begin
                            sda_oe  <= 1'b0;
                            bit_cnt <= 3'd0;
                            state_q <= RX;
                        end
                    end

                    TX: begin
                        if (scl_rise && !byte_done) begin
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) byte_done <= 1'b1;
                        end else if (scl_fall) begin
                            if (byte_done) begin
                                byte_done <= 1'b0;
                                sda_oe    <= 1'b0;
                                state_q   <= TX_ACK;
                            end else begin
                                sda_oe  <= ~tx_rest[6];
                                tx_rest <= {tx_rest[5:0], 1'b0};
                            end
                        end
                    end

                    TX_ACK: begin
                        if (scl_rise) begin
                            mack <= sda_s2;
                        end else if (scl_fall) begin
                            if (!mack) begin
                                tx_load <= 1'b1;
                                tx_rest <= tx_data[6:0];
                                sda_oe  <= ~tx_data[7];
                                bit_cnt <= 3'd0;
                                state_q <= TX;
                            end else begin
                                sda_oe  <= 1'b0;
                                state_q <= WAIT;
                            end
                        end
                    end

                    WAIT: ;

                    default: begin
                        sda_oe  <= 1'b0;
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

    assign state = state_q;
    assign busy  = (state_q != IDLE);

endmodule

// File: tb/tb_i2c_slave.sv
// Directed bench for i2c_slave: a bit-banged bus master with wired-AND SDA
// and hand-computed expectations for each step.
module tb_i2c_slave;

    localparam int Q = 5;   // clk cycles per quarter sclk period

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sclk = 1'b1;
    logic       sda_m = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       sda_in;
    logic       sda_oe;
    logic       tx_load;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [3:0] state;
    logic       busy;

    int tests = 0;
    int failed = 0;
    int rx_cnt = 0;
    int txl_cnt = 0;

    // Open-drain bus: either side can pull low.
    assign sda_in = sda_m & ~sda_oe;

    always #5 clk = ~clk;

    i2c_slave #(.ADDR(7'h42)) dut (
        .clk      (clk),
        .rst      (rst),
        .sclk     (sclk),
        .sda_in   (sda_in),
        .sda_oe   (sda_oe),
        .tx_data  (tx_data),
        .tx_load  (tx_load),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .state    (state),
        .busy     (busy)
    );

    // Pulse counters for rx_valid and tx_load.
    always @(posedge clk) begin
        if (rx_valid) rx_cnt++;
        if (tx_load)  txl_cnt++;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; tick(Q);
        sclk  = 1'b1; tick(Q);
        sda_m = 1'b0; tick(Q);
        sclk  = 1'b0; tick(Q);
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; tick(Q);
        sclk  = 1'b1; tick(Q);
        sda_m = 1'b1; tick(Q);
    endtask

    task automatic send_bit(input logic b);
        sda_m = b;    tick(Q);
        sclk  = 1'b1; tick(2 * Q);
        sclk  = 1'b0; tick(Q);
    endtask

    // Master write of one byte; checks target ACK drive and state during ACK high.
    task automatic write_byte(input logic [7:0] b, input logic exp_oe,
                              input logic [3:0] exp_st, input string tag);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        sda_m = 1'b1; tick(Q);
        sclk  = 1'b1; tick(Q);
        check({tag, " ack oe"}, sda_oe, exp_oe);
        check({tag, " ack state"}, state, exp_st);
        tick(Q);
        sclk  = 1'b0; tick(Q);
    endtask

    // Master read of one byte followed by ACK (nack=0) or NACK (nack=1).
    task automatic read_byte(input logic [7:0] exp, input logic nack, input string tag);
        logic [7:0] got;
        got = 8'h00;
        for (int i = 7; i >= 0; i--) begin
            sda_m = 1'b1; tick(Q);
            sclk  = 1'b1; tick(Q);
            got[i] = sda_in;
            tick(Q);
            sclk  = 1'b0; tick(Q);
        end
        check({tag, " data"}, got, exp);
        sda_m = nack; tick(Q);
        sclk  = 1'b1; tick(2 * Q);
        sclk  = 1'b0; tick(Q);
    endtask

    initial begin
        logic [2:0] part;

        // Reset state
        rst = 1'b1; tick(3);
        rst = 1'b0; tick(2);
        check("rst state", state, 4'd0);
        check("rst oe", sda_oe, 1'b0);
        check("rst busy", busy, 1'b0);
        check("rst rx_data", rx_data, 8'h00);
        check("rst rx_valid", rx_valid, 1'b0);
        check("rst tx_load", tx_load, 1'b0);

        // 1: write 0xA5 to address 0x42
        i2c_start();
        check("t1 start state", state, 4'd1);
        check("t1 start busy", busy, 1'b1);
        write_byte(8'h84, 1'b1, 4'd2, "t1 addr");
        check("t1 post-addr state", state, 4'd3);
        check("t1 post-addr oe", sda_oe, 1'b0);
        write_byte(8'hA5, 1'b1, 4'd4, "t1 data");
        check("t1 rx_data", rx_data, 8'hA5);
        check("t1 rx count", rx_cnt, 1);
        check("t1 post-data state", state, 4'd3);
        i2c_stop();
        check("t1 stop state", state, 4'd0);
        check("t1 stop busy", busy, 1'b0);

        // 2: address mismatch
        i2c_start();
        write_byte(8'h86, 1'b0, 4'd7, "t2 addr");
        write_byte(8'h5A, 1'b0, 4'd7, "t2 data");
        check("t2 rx count", rx_cnt, 1);
        i2c_stop();
        check("t2 stop state", state, 4'd0);

        // 3: read two bytes, ACK then NACK
        tx_data = 8'h3C;
        i2c_start();
        write_byte(8'h85, 1'b1, 4'd2, "t3 addr");
        check("t3 tx_load count 1", txl_cnt, 1);
        check("t3 tx state", state, 4'd5);
        tx_data = 8'hF0;
        read_byte(8'h3C, 1'b0, "t3 byte0");
        check("t3 tx_load count 2", txl_cnt, 2);
        check("t3 tx state 2", state, 4'd5);
        read_byte(8'hF0, 1'b1, "t3 byte1");
        check("t3 nack state", state, 4'd7);
        check("t3 nack oe", sda_oe, 1'b0);
        check("t3 tx_load count final", txl_cnt, 2);
        i2c_stop();
        check("t3 stop state", state, 4'd0);

        // 4: repeated START in the middle of a received byte
        i2c_start();
        write_byte(8'h84, 1'b1, 4'd2, "t4 addr0");
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        i2c_start();
        check("t4 rstart state", state, 4'd1);
        check("t4 rstart rx count", rx_cnt, 1);
        write_byte(8'h84, 1'b1, 4'd2, "t4 addr1");
        write_byte(8'h11, 1'b1, 4'd4, "t4 data");
        check("t4 rx_data", rx_data, 8'h11);
        check("t4 rx count", rx_cnt, 2);
        i2c_stop();
        check("t4 stop state", state, 4'd0);

        // 5: STOP after three bits of a read byte (fourth bit of 0x3C is 1, bus released)
        tx_data = 8'h3C;
        i2c_start();
        write_byte(8'h85, 1'b1, 4'd2, "t5 addr");
        part = 3'b000;
        for (int i = 2; i >= 0; i--) begin
            sda_m = 1'b1; tick(Q);
            sclk  = 1'b1; tick(Q);
            part[i] = sda_in;
            tick(Q);
            sclk  = 1'b0; tick(Q);
        end
        check("t5 partial bits", part, 3'b001);
        i2c_stop();
        check("t5 stop state", state, 4'd0);
        check("t5 stop oe", sda_oe, 1'b0);
        check("t5 stop busy", busy, 1'b0);

        // 6: reset while the target is driving the address ACK
        i2c_start();
        for (int i = 7; i >= 0; i--) send_bit(i == 7 || i == 2);
        sda_m = 1'b1; tick(Q);
        sclk  = 1'b1; tick(Q);
        check("t6 pre-rst oe", sda_oe, 1'b1);
        check("t6 pre-rst state", state, 4'd2);
        rst = 1'b1; tick(1);
        rst = 1'b0;
        check("t6 rst oe", sda_oe, 1'b0);
        check("t6 rst state", state, 4'd0);
        check("t6 rst busy", busy, 1'b0);
        sclk = 1'b0; tick(Q);
        i2c_start();
        check("t6 restart state", state, 4'd1);
        write_byte(8'h84, 1'b1, 4'd2, "t6 addr");
        i2c_stop();
        check("t6 stop state", state, 4'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
